ikbd_link: RTL and testbench

Host-side end of the IKBD serial link, a 6850-ACIA-style subset. Deserialises the 8N1 byte stream the keyboard controller drives on its TX pin into a small receive FIFO. Serialises host command bytes onto the keyboard controller's RX pin. Runs on the same 2 MHz clock as the keyboard controller: 256 clocks per bit, i.e. 7812.5 baud.

---
 rtl/ikbd_link_pkg.sv | 29 ++
 rtl/ikbd_link_fifo.sv | 94 +++++++++
 rtl/ikbd_link.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_ikbd_link.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ikbd_link_pkg.sv
// ----------------------------------------------------------------------------
// ikbd_link_pkg
// Shared constants and state encodings for the host side of the IKBD serial
// link. The keyboard controller and host share one 2 MHz clock, so the bit
// period is a fixed clock count (256 clocks per bit, 7812.5 baud).
// ----------------------------------------------------------------------------
package ikbd_link_pkg;

   localparam int IKBD_CLKS_PER_BIT = 256;
   localparam int IKBD_FIFO_DEPTH   = 4;

   // Receive deserialiser states
   typedef enum logic [2:0] {
      R_IDLE  = 3'd0,
      R_START = 3'd1,
      R_DATA  = 3'd2,
      R_STOP  = 3'd3,
      R_BREAK = 3'd4
   } rx_state_t;

   // Transmit serialiser states
   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_START = 2'd1,
      T_DATA  = 2'd2,
      T_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/ikbd_link_fifo.sv
// ----------------------------------------------------------------------------
// ikbd_link_fifo
// Synchronous show-ahead FIFO: the head entry is presented on 'head' while
// the FIFO is non-empty. A pop on an empty FIFO is ignored. A push on a full
// FIFO is accepted only when a pop happens in the same cycle; otherwise it is
// discarded and the contents stay unchanged (the parent flags that as
// overrun).
//
// Ports:
//   clk        in   clock
//   res        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data
//   push_data  in   WIDTH  data to write
//   pop        in   remove head entry
//   head       out  WIDTH  current head entry
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module ikbd_link_fifo
   import ikbd_link_pkg::*;
#(
   parameter int DEPTH = IKBD_FIFO_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_ZERO = LW'(0);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign full  = (level_r == LVL_FULL);
   assign empty = (level_r == LVL_ZERO);

   // A pop frees a slot in the same cycle, so a push while full still lands
   // when it coincides with a pop.
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Storage array write; cleared on reset so the head never reads unknown
   always_ff @(posedge clk) begin
      if (res) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Read/write pointers (wrap naturally, DEPTH is a power of two) and level
   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= LVL_ZERO;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign level = level_r;

endmodule

// File: rtl/ikbd_link.sv
// ----------------------------------------------------------------------------
// ikbd_link
// Host-side end of the IKBD serial link (6850-ACIA-style subset).
// Receives 8N1 bytes from the keyboard controller's TX pin into a small
// show-ahead FIFO, and transmits host command bytes onto its RX pin.
//
// Ports:
//   clk           in   system clock (2 MHz)
//   res           in   synchronous active-high reset
//   ikbd_tx       in   serial data from keyboard controller, idle high, async
//   ikbd_rx       out  serial data to keyboard controller, idle high
//   rx_data       out  8   head of receive FIFO
//   rx_valid      out  receive FIFO non-empty
//   rx_ack        in   pop head (ignored while rx_valid=0)
//   rx_level      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   rx_overrun    out  sticky: byte dropped because FIFO was full
//   rx_frame_err  out  sticky: stop bit sampled low
//   err_clr       in   clears both sticky flags (a same-cycle event wins)
//   tx_data       in   8   byte to send
//   tx_wr         in   write strobe, accepted only while tx_ready=1
//   tx_ready      out  transmitter idle
// ----------------------------------------------------------------------------
module ikbd_link
   import ikbd_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = IKBD_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = IKBD_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic                          ikbd_tx,
   output logic                          ikbd_rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ack,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          rx_overrun,
   output logic                          rx_frame_err,
   input  logic                          err_clr,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_wr,
   output logic                          tx_ready
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   // Counters count down to zero, so a load of N-1 expires N cycles later.
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [2:0]    BIT_ZERO = 3'd0;
   localparam logic [2:0]    BIT_ONE  = 3'd1;
   localparam logic [2:0]    BIT_LAST = 3'd7;

   // ---------------------------------------------------------------- sync --
   logic sync1_r;
   logic sync2_r;
   logic rxs_prev_r;
   logic rxs_s;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (res) begin
         sync1_r    <= 1'b1;
         sync2_r    <= 1'b1;
         rxs_prev_r <= 1'b1;
      end else begin
         sync1_r    <= ikbd_tx;
         sync2_r    <= sync1_r;
         rxs_prev_r <= sync2_r;
      end
   end

   assign rxs_s = sync2_r;

   // ------------------------------------------------------------------ RX --
   rx_state_t        rx_state_r;
   rx_state_t        rx_state_n;
   logic [CW-1:0]    rx_cnt_r;
   logic [CW-1:0]    rx_cnt_n;
   logic [2:0]       rx_bit_r;
   logic [2:0]       rx_bit_n;
   logic [7:0]       rx_shift_r;
   logic [7:0]       rx_shift_n;
   logic             push_s;
   logic             frame_evt_s;

   // RX state and datapath registers
   always_ff @(posedge clk) begin
      if (res) begin
         rx_state_r <= R_IDLE;
         rx_cnt_r   <= CNT_ZERO;
         rx_bit_r   <= BIT_ZERO;
         rx_shift_r <= 8'h00;
      end else begin
         rx_state_r <= rx_state_n;
         rx_cnt_r   <= rx_cnt_n;
         rx_bit_r   <= rx_bit_n;
         rx_shift_r <= rx_shift_n;
      end
   end

   // RX next-state: sample mid-bit, shift LSB first, check the stop bit
   always_comb begin
      rx_state_n  = rx_state_r;
      rx_cnt_n    = rx_cnt_r;
      rx_bit_n    = rx_bit_r;
      rx_shift_n  = rx_shift_r;
      push_s      = 1'b0;
      frame_evt_s = 1'b0;
      case (rx_state_r)
         R_IDLE: begin
            if (rxs_prev_r & ~rxs_s) begin
               rx_state_n = R_START;
               rx_cnt_n   = CNT_HALF;
            end else begin
               rx_state_n = R_IDLE;
            end
         end
         R_START: begin
            if (rx_cnt_r != CNT_ZERO) begin
               rx_cnt_n = rx_cnt_r - CNT_ONE;
            end else if (rxs_s) begin
               // line back high at mid-start: a glitch, not a frame
               rx_state_n = R_IDLE;
            end else begin
               rx_state_n = R_DATA;
               rx_cnt_n   = CNT_FULL;
               rx_bit_n   = BIT_ZERO;
            end
         end
         R_DATA: begin
            if (rx_cnt_r != CNT_ZERO) begin
               rx_cnt_n = rx_cnt_r - CNT_ONE;
            end else begin
               rx_shift_n = {rxs_s, rx_shift_r[7:1]};
               rx_cnt_n   = CNT_FULL;
               if (rx_bit_r == BIT_LAST) begin
                  rx_state_n = R_STOP;
               end else begin
                  rx_bit_n = rx_bit_r + BIT_ONE;
               end
            end
         end
         R_STOP: begin
            if (rx_cnt_r != CNT_ZERO) begin
               rx_cnt_n = rx_cnt_r - CNT_ONE;
            end else if (rxs_s) begin
               push_s     = 1'b1;
               rx_state_n = R_IDLE;
            end else begin
               frame_evt_s = 1'b1;
               rx_state_n  = R_BREAK;
            end
         end
         R_BREAK: begin
            // hold off until the line is released so a long low level
            // does not look like a new start bit
            if (rxs_s) begin
               rx_state_n = R_IDLE;
            end else begin
               rx_state_n = R_BREAK;
            end
         end
         default: begin
            rx_state_n = R_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- FIFO --
   logic fifo_full_s;
   logic fifo_empty_s;
   logic ovr_evt_s;

   ikbd_link_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .res       (res),
      .push      (push_s),
      .push_data (rx_shift_r),
      .pop       (rx_ack),
      .head      (rx_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (rx_level)
   );

   assign rx_valid = ~fifo_empty_s;

   // Full implies non-empty, so rx_ack alone means a real pop here.
   assign ovr_evt_s = push_s & fifo_full_s & ~rx_ack;

   // ---------------------------------------------------------- sticky flags --
   logic ovr_r;
   logic ferr_r;

   // Sticky error flags; a new event outranks a same-cycle clear
   always_ff @(posedge clk) begin
      if (res) begin
         ovr_r  <= 1'b0;
         ferr_r <= 1'b0;
      end else begin
         if (ovr_evt_s) begin
            ovr_r <= 1'b1;
         end else if (err_clr) begin
            ovr_r <= 1'b0;
         end else begin
            ovr_r <= ovr_r;
         end
         if (frame_evt_s) begin
            ferr_r <= 1'b1;
         end else if (err_clr) begin
            ferr_r <= 1'b0;
         end else begin
            ferr_r <= ferr_r;
         end
      end
   end

   assign rx_overrun   = ovr_r;
   assign rx_frame_err = ferr_r;

   // ------------------------------------------------------------------ TX --
   tx_state_t        tx_state_r;
   tx_state_t        tx_state_n;
   logic [CW-1:0]    tx_cnt_r;
   logic [CW-1:0]    tx_cnt_n;
   logic [2:0]       tx_bit_r;
   logic [2:0]       tx_bit_n;
   logic [7:0]       tx_shift_r;
   logic [7:0]       tx_shift_n;
   logic             tx_line_r;
   logic             tx_line_n;
   logic             tx_ready_r;
   logic             tx_ready_n;

   // TX state, datapath and registered line/ready outputs
   always_ff @(posedge clk) begin
      if (res) begin
         tx_state_r <= T_IDLE;
         tx_cnt_r   <= CNT_ZERO;
         tx_bit_r   <= BIT_ZERO;
         tx_shift_r <= 8'h00;
         tx_line_r  <= 1'b1;
         tx_ready_r <= 1'b1;
      end else begin
         tx_state_r <= tx_state_n;
         tx_cnt_r   <= tx_cnt_n;
         tx_bit_r   <= tx_bit_n;
         tx_shift_r <= tx_shift_n;
         tx_line_r  <= tx_line_n;
         tx_ready_r <= tx_ready_n;
      end
   end

   // TX next-state: the line value for the next cycle is decided here and
   // registered, so each bit lasts exactly CLKS_PER_BIT cycles
   always_comb begin
      tx_state_n = tx_state_r;
      tx_cnt_n   = tx_cnt_r;
      tx_bit_n   = tx_bit_r;
      tx_shift_n = tx_shift_r;
      tx_line_n  = tx_line_r;
      tx_ready_n = tx_ready_r;
      case (tx_state_r)
         T_IDLE: begin
            if (tx_wr & tx_ready_r) begin
               tx_state_n = T_START;
               tx_cnt_n   = CNT_FULL;
               tx_shift_n = tx_data;
               tx_line_n  = 1'b0;
               tx_ready_n = 1'b0;
            end else begin
               tx_line_n  = 1'b1;
               tx_ready_n = 1'b1;
            end
         end
         T_START: begin
            if (tx_cnt_r != CNT_ZERO) begin
               tx_cnt_n = tx_cnt_r - CNT_ONE;
            end else begin
               tx_state_n = T_DATA;
               tx_cnt_n   = CNT_FULL;
               tx_bit_n   = BIT_ZERO;
               tx_line_n  = tx_shift_r[0];
               tx_shift_n = {1'b0, tx_shift_r[7:1]};
            end
         end
         T_DATA: begin
            if (tx_cnt_r != CNT_ZERO) begin
               tx_cnt_n = tx_cnt_r - CNT_ONE;
            end else if (tx_bit_r == BIT_LAST) begin
               tx_state_n = T_STOP;
               tx_cnt_n   = CNT_FULL;
               tx_line_n  = 1'b1;
            end else begin
               tx_cnt_n   = CNT_FULL;
               tx_bit_n   = tx_bit_r + BIT_ONE;
               tx_line_n  = tx_shift_r[0];
               tx_shift_n = {1'b0, tx_shift_r[7:1]};
            end
         end
         T_STOP: begin
            if (tx_cnt_r != CNT_ZERO) begin
               tx_cnt_n = tx_cnt_r - CNT_ONE;
            end else begin
               tx_state_n = T_IDLE;
               tx_line_n  = 1'b1;
               tx_ready_n = 1'b1;
            end
         end
         default: begin
            tx_state_n = T_IDLE;
            tx_line_n  = 1'b1;
            tx_ready_n = 1'b1;
         end
      endcase
   end

   assign ikbd_rx  = tx_line_r;
   assign tx_ready = tx_ready_r;

endmodule

// File: tb/tb_ikbd_link.sv
// ----------------------------------------------------------------------------
// tb_ikbd_link
// Directed bench for ikbd_link. Received bytes are predicted into a
// scoreboard queue as frames are driven and compared when popped; the
// transmit line is compared cycle by cycle against a bit-period model.
// ----------------------------------------------------------------------------
module tb_ikbd_link;

   localparam int CPB   = 256;
   localparam int DEPTH = 4;

   logic                      clk = 1'b0;
   logic                      res = 1'b1;
   logic                      ikbd_tx = 1'b1;
   logic                      ikbd_rx;
   logic [7:0]                rx_data;
   logic                      rx_valid;
   logic                      rx_ack = 1'b0;
   logic [$clog2(DEPTH):0]    rx_level;
   logic                      rx_overrun;
   logic                      rx_frame_err;
   logic                      err_clr = 1'b0;
   logic [7:0]                tx_data = 8'h00;
   logic                      tx_wr = 1'b0;
   logic                      tx_ready;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rise_cyc = -1;
   int         frame_p = 0;
   logic       valid_q = 1'b0;
   logic [7:0] sb [$];

   ikbd_link #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .res          (res),
      .ikbd_tx      (ikbd_tx),
      .ikbd_rx      (ikbd_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ack       (rx_ack),
      .rx_level     (rx_level),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err),
      .err_clr      (err_clr),
      .tx_data      (tx_data),
      .tx_wr        (tx_wr),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   // cycle number: after the k-th rising edge cyc reads k
   always @(posedge clk) cyc <= cyc + 1;

   // record the cycle in which rx_valid most recently went 0 -> 1
   always @(negedge clk) begin
      if (rx_valid === 1'b1 && valid_q !== 1'b1) rise_cyc <= cyc;
      valid_q <= rx_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // level of the keyboard-side TX pin, i cycles after the start edge
   function automatic logic rx_line(input logic [7:0] b, input int i, input int stop_low);
      if (i < CPB) return 1'b0;
      else if (i < 9 * CPB) return b[(i / CPB) - 1];
      else if (i < (9 + stop_low) * CPB) return 1'b0;
      else return 1'b1;
   endfunction

   // expected ikbd_rx j cycles after the tx_wr acceptance cycle
   function automatic logic tx_line(input logic [7:0] b, input int j);
      if (j < 1) return 1'b1;
      else if (j <= CPB) return 1'b0;
      else if (j <= 9 * CPB) return b[((j - 1) / CPB) - 1];
      else return 1'b1;
   endfunction

   function automatic logic tx_rdy(input int j);
      return !(j >= 1 && j <= 10 * CPB);
   endfunction

   // drive one frame; stop bit held low for stop_low extra bit times;
   // rx_ack / err_clr pulsed at the given cycle offsets (-1 = never)
   task automatic send_frame(input logic [7:0] b, input int stop_low,
                             input int ack_at, input int clr_at);
      int len;
      len = (10 + stop_low) * CPB;
      frame_p = cyc;
      for (int i = 0; i < len; i++) begin
         ikbd_tx = rx_line(b, i, stop_low);
         rx_ack  = (i == ack_at);
         err_clr = (i == clr_at);
         step();
      end
      rx_ack  = 1'b0;
      err_clr = 1'b0;
      ikbd_tx = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      e = 8'h00;
      check({tag, "_valid"}, rx_valid, 1);
      if (sb.size() > 0) e = sb.pop_front();
      check(tag, rx_data, e);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
   endtask

   initial begin
      // ---- reset state
      step(); step(); step();
      check("rst_ikbd_rx", ikbd_rx, 1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_level", rx_level, 0);
      check("rst_flags", {rx_overrun, rx_frame_err}, 0);
      res = 1'b0;
      step(); step();

      // ---- 1: transmit 0x80, second write inside the busy window ignored
      for (int i = 0; i <= 2600; i++) begin
         tx_wr   = (i == 0) || (i == 500);
         tx_data = (i == 500) ? 8'h00 : 8'h80;
         check("t1_line", ikbd_rx, tx_line(8'h80, i));
         check("t1_ready", tx_ready, tx_rdy(i));
         step();
      end
      tx_wr = 1'b0;

      // ---- 2: receive 0xF6, exact visibility cycle, then pop
      sb.push_back(8'hF6);
      send_frame(8'hF6, 0, -1, -1);
      check("t2_rise_cycle", rise_cyc, frame_p + 2 + CPB / 2 + 9 * CPB + 1);
      check("t2_level", rx_level, 1);
      pop_check("t2_data");
      check("t2_valid_after_ack", rx_valid, 0);

      // ---- 3: 100-cycle glitch, then a real frame
      ikbd_tx = 1'b0;
      repeat (100) step();
      ikbd_tx = 1'b1;
      repeat (3000) step();
      check("t3_no_push", rx_valid, 0);
      check("t3_no_flags", {rx_overrun, rx_frame_err}, 0);
      sb.push_back(8'h12);
      send_frame(8'h12, 0, -1, -1);
      pop_check("t3_data");

      // ---- 4a: five frames into a four-entry FIFO without popping
      for (int k = 1; k <= 5; k++) begin
         if (k <= DEPTH) sb.push_back(8'(k));
         send_frame(8'(k), 0, -1, -1);
      end
      check("t4_level_full", rx_level, DEPTH);
      check("t4_overrun", rx_overrun, 1);
      for (int k = 1; k <= DEPTH; k++) pop_check("t4_pop");
      check("t4_empty", rx_valid, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t4_ovr_cleared", rx_overrun, 0);

      // ---- 4b: fifth push coincides with rx_ack -> no overrun
      for (int k = 1; k <= DEPTH; k++) begin
         sb.push_back(8'(k));
         send_frame(8'(k), 0, -1, -1);
      end
      void'(sb.pop_front());
      sb.push_back(8'h05);
      send_frame(8'h05, 0, 2 + CPB / 2 + 9 * CPB, -1);
      check("t4b_no_overrun", rx_overrun, 0);
      check("t4b_level", rx_level, DEPTH);
      for (int k = 1; k <= DEPTH; k++) pop_check("t4b_pop");
      check("t4b_empty", rx_level, 0);

      // ---- 5: frame error with held-low stop bit
      send_frame(8'h55, 3, -1, -1);
      repeat (50) step();
      check("t5_ferr", rx_frame_err, 1);
      check("t5_nothing_pushed", rx_valid, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t5_ferr_cleared", rx_frame_err, 0);
      send_frame(8'h55, 3, -1, 2 + CPB / 2 + 9 * CPB);
      check("t5_ferr_beats_clear", rx_frame_err, 1);
      check("t5_still_empty", rx_valid, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;

      // ---- 6: reset during TX data bit 3 and RX data bit 5
      sb.push_back(8'h77);
      send_frame(8'h77, 0, -1, -1);
      for (int i = 0; i <= 1600; i++) begin
         ikbd_tx = rx_line(8'h5A, i, 0);
         tx_wr   = (i == 500);
         tx_data = 8'h30;
         if (i == 1600) begin
            res = 1'b1;
            check("t6_pre_line", ikbd_rx, tx_line(8'h30, i - 500));
            check("t6_pre_valid", rx_valid, 1);
         end
         step();
      end
      res     = 1'b0;
      tx_wr   = 1'b0;
      ikbd_tx = 1'b1;
      check("t6_rst_line", ikbd_rx, 1);
      check("t6_rst_ready", tx_ready, 1);
      check("t6_rst_valid", rx_valid, 0);
      check("t6_rst_level", rx_level, 0);
      sb.delete();
      repeat (3000) step();
      check("t6_no_spurious", rx_valid, 0);

      // full-duplex 0xA5 exchange
      sb.push_back(8'hA5);
      for (int i = 0; i <= 2600; i++) begin
         ikbd_tx = rx_line(8'hA5, i, 0);
         tx_wr   = (i == 0);
         tx_data = 8'hA5;
         check("t6_tx_line", ikbd_rx, tx_line(8'hA5, i));
         check("t6_tx_ready", tx_ready, tx_rdy(i));
         step();
      end
      tx_wr   = 1'b0;
      ikbd_tx = 1'b1;
      pop_check("t6_rx_data");
      check("t6_flags", {rx_overrun, rx_frame_err}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
